// File: rtl/serial_subtractor_nb.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin, LSB first, one bit per clock) with a start/busy/done handshake.
// Latency: done pulses in the cycle after edge WIDTH (start edge = edge 0). No backpressure: start is taken only in IDLE, never queued.
module serial_subtractor_nb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;

  logic             d_bit;
  logic             brw_nxt;
  logic [WIDTH-1:0] res_nxt;
  logic             last_bit;

  // One full-subtractor cell applied to the current LSBs.
  always_comb begin
    d_bit    = sa[0] ^ sb[0] ^ brw;
    brw_nxt  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & brw);
    res_nxt  = {d_bit, res[WIDTH-1:1]};
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            brw   <= bin;
            res   <= '0;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= res_nxt;
          brw <= brw_nxt;
          cnt <= cnt + CW'(1);
          // Results are published only on the final bit so partial sums never leak out.
          if (last_bit) begin
            diff <= res_nxt;
            bout <= brw_nxt;
            ovf  <= (a_msb != b_msb) && (d_bit != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: doc/serial_subtractor_nb.md
Name: serial_subtractor_nb

Overview:
- Bit-serial N-bit subtractor computing A - B - bin, LSB first, one bit per clock.
- Core is a 1-bit full subtractor: diff = a^b^borrow, borrow_out = (~a&b) | (~(a^b)&borrow).
- A registered borrow flip-flop carries the borrow between bits.
- It is the inverse-operation counterpart of the team's 1-bit full adder, controlled by a small FSM with a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high; takes effect on the rising edge of clk.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  borrow-in; captured on the accepting edge.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  result A - B - bin, modulo 2^WIDTH.
- bout  output  1  final borrow-out (unsigned A < B + bin).
- ovf  output  1  signed (two's complement) overflow.

Behaviour:
- Clock and reset: single clock domain, clk; reset is synchronous and active-high on rst.
- Reset: state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0. Internal shift registers, bit counter and borrow FF are cleared.
- Reset mid-operation: abort on that edge. No done pulse; outputs return to 0.
- FSM states: IDLE, SHIFT, DONE. All outputs are registered; busy and done are Moore outputs.
- IDLE:
  - If start=1 at edge 0: load a into shift reg SA, b into SB, bin into the borrow FF; cnt=0; go to SHIFT.
  - Otherwise remain in IDLE.
- SHIFT (busy=1), on each edge:
  - Compute d = SA[0]^SB[0]^brw.
  - Shift d into the result reg MSB-side (result reg shifts right).
  - Update brw with the borrow equation; shift SA and SB right by one.
  - cnt += 1.
  - On the edge processing bit WIDTH-1 (edge WIDTH after the start edge), go to DONE.
- Final-bit capture: on the same edge (edge WIDTH), diff is loaded with the completed result, bout with the final borrow, and ovf with (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), using the captured operand MSBs.
- DONE: done=1 for exactly one cycle (between edges WIDTH and WIDTH+1), busy=0. Next edge goes to IDLE.
- Latency: the start edge is edge 0. done is high in the cycle following edge WIDTH, and the result is valid from that cycle on.
- Result hold: diff/bout/ovf hold their values until the next completed operation or reset. They never show partial results during SHIFT.
- start handling:
  - start is ignored in SHIFT and DONE; no queuing.
  - A start held high continuously re-triggers on the first IDLE cycle.
  - Operand changes after the accepting edge have no effect.
- bin=1 with a=b gives diff = all ones, bout=1.
- cnt width is clog2(WIDTH). Wrap-around of cnt is never relied upon; the exit condition is cnt==WIDTH-1.

Test Plan (WIDTH=8):
1. Reset, then start with a=0x05, b=0x03, bin=0 -> busy high for 8 cycles, then done pulses once exactly 8 edges after the start edge; diff=0x02, bout=0, ovf=0.
2. a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0. Values hold after done until the next operation.
3. a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Also a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
4. a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0. Then a=0xAA, b=0xAA, bin=0 -> diff=0x00, bout=0.
5. start pulsed again at cycles 3 and 8 (in SHIFT) and during DONE, with different operands -> ignored. The first result is unchanged and there is exactly one done pulse. A new start in IDLE then completes normally.
6. rst asserted at cycle 4 of SHIFT -> next edge: busy=0, diff/bout/ovf=0, no done pulse. A subsequent start with a=0x10, b=0x01 -> diff=0x0F, bout=0, with correct 8-cycle latency.
